axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
// - Packet-level N:1 AXI4-Stream arbiter in front of axis_switch. Merges NUM_S upstream streams onto one stream.
// - Round-robin grant; a grant is held until the granted port's tlast beat is accepted, so packets never interleave.
// - Registered output stage (one beat deep); tdest passes through unchanged for downstream routing.
// PARAMETERS
// - NUM_S   default 2  number of upstream (slave) ports, 2..8
// - DATA_W  default 8  tdata width per port
// - DEST_W  default 5  tdest width per port
// PORTS
// - i_switch_clk  in   1             single clock; all logic on rising edge
// - i_switch_rst  in   1             reset, asynchronous, active-high
// - i_s_tvalid    in   NUM_S         per-port tvalid
// - i_s_tlast     in   NUM_S         per-port tlast
// - i_s_tdest     in   NUM_S*DEST_W  port k in bits [k*DEST_W +: DEST_W]
// - i_s_tdata     in   NUM_S*DATA_W  port k in bits [k*DATA_W +: DATA_W]
// - o_s_tready    out  NUM_S         per-port tready (combinational, see below)
// - i_m_tready    in   1             downstream tready
// - o_m_tvalid    out  1             registered
// - o_m_tlast     out  1             registered
// - o_m_tdest     out  DEST_W        registered
// - o_m_tdata     out  DATA_W        registered
// - o_grant       out  NUM_S         one-hot current grant; 0 in IDLE
// - o_busy        out  1             1 while in XFER
// BEHAVIOUR
// - Reset (async, immediate): o_m_* = 0, o_grant = 0, o_busy = 0, state = IDLE, last_ptr = NUM_S-1 (port 0 wins first).
// - States: IDLE, XFER.
//   IDLE: o_s_tready = 0. If any i_s_tvalid: pick the first asserted port searching (last_ptr+1) mod NUM_S upward
//         with wrap; register the grant and go to XFER next cycle. No request: stay in IDLE.
//   XFER: o_s_tready[g] = !o_m_tvalid | i_m_tready; all other ready bits are 0. A beat is accepted when
//         i_s_tvalid[g] & o_s_tready[g] and loads the output register with o_m_tvalid = 1.
//         Accepted beat with tlast = 1 -> IDLE next cycle, last_ptr <= g, o_grant <= 0.
// - Output register: holds its value while o_m_tvalid & !i_m_tready (AXIS stable rule). Cleared (o_m_tvalid <= 0)
//   on i_m_tready with no new load. Load and drain in the same cycle gives back-to-back beats.
// - Latency: tvalid rising in IDLE -> o_grant set at edge 1 -> beat on o_m_* at edge 2. Full throughput within
//   a packet. One bubble cycle between packets (the IDLE arbitration cycle); the output register drains during IDLE.
// - Simultaneous requests: the rotating pointer decides. A port that loses is served no later than after NUM_S-1 packets.
// - Granted port drops tvalid mid-packet: grant is held and the arbiter waits; no timeout.
// - Single-beat packet (tlast on the first beat): exactly one cycle in XFER if not backpressured.
// - Reset mid-packet: partial packet is discarded, outputs clear at once, arbitration restarts at port 0.
// - Width rule: the pointer is $clog2(NUM_S) bits, with explicit wrap at NUM_S-1 (NUM_S need not be a power of 2).
// CONFIGURATION
// - AXIS_ARB_FIXED_PRIO_EN defined: IDLE always grants the lowest-index requesting port; last_ptr is unused.
//   Starvation of higher indices is permitted.
// - Not defined (default): round-robin as above.
// TESTING
// - Reset: assert i_switch_rst mid-XFER -> same-cycle o_m_tvalid=0, o_grant=0, o_busy=0; after release port 0 wins first.
// - Single port: port0 sends a 3-beat packet 0xA1,0xA2,0xA3 with tdest=5'h01 and m_tready=1 ->
//   o_m_tdata A1..A3 on consecutive cycles starting 2 cycles after tvalid; o_m_tlast on A3 only.
// - Contention: both ports hold 2-beat packets (port0 0x10,0x11; port1 0x20,0x21) ->
//   output order 10,11,20,21; a second round again starts with port0.
// - Backpressure: i_m_tready=0 for 3 cycles mid-packet -> o_m_* held stable, o_s_tready[g]=0, no beat lost or duplicated.
// - No interleave: port1 raises tvalid while port0 is mid-packet -> o_grant stays 2'b01 until port0's tlast is accepted.
// - AXIS_ARB_FIXED_PRIO_EN: both ports requesting continuously -> only port0 packets appear on the output.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-level N:1 AXI4-Stream arbiter with a registered one-beat output stage.
// Define AXIS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axis_rr_arbiter #(
  parameter int NUM_S  = 2,
  parameter int DATA_W = 8,
  parameter int DEST_W = 5
) (
  input  logic                     i_switch_clk,
  input  logic                     i_switch_rst,
  input  logic [NUM_S-1:0]         i_s_tvalid,
  input  logic [NUM_S-1:0]         i_s_tlast,
  input  logic [NUM_S*DEST_W-1:0]  i_s_tdest,
  input  logic [NUM_S*DATA_W-1:0]  i_s_tdata,
  output logic [NUM_S-1:0]         o_s_tready,
  input  logic                     i_m_tready,
  output logic                     o_m_tvalid,
  output logic                     o_m_tlast,
  output logic [DEST_W-1:0]        o_m_tdest,
  output logic [DATA_W-1:0]        o_m_tdata,
  output logic [NUM_S-1:0]         o_grant,
  output logic                     o_busy
);

  localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t state;

  logic              out_ready;
  logic              accept;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [DEST_W-1:0] sel_dest;
  logic [NUM_S-1:0]  pick_onehot;

`ifndef AXIS_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] pick_idx;
  int               cand;
`endif

  // Mux the granted port; grant is one-hot so at most one iteration matches.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_dest  = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (o_grant[k]) begin
        sel_valid = i_s_tvalid[k];
        sel_last  = i_s_tlast[k];
        sel_data  = i_s_tdata[k*DATA_W +: DATA_W];
        sel_dest  = i_s_tdest[k*DEST_W +: DEST_W];
      end
    end
  end

  assign out_ready  = !o_m_tvalid || i_m_tready;
  assign accept     = (state == XFER) && sel_valid && out_ready;
  assign o_s_tready = ((state == XFER) && out_ready) ? o_grant : '0;

`ifdef AXIS_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last to write.
  always_comb begin
    pick_onehot = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (i_s_tvalid[i]) begin
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
      end
    end
  end
`else
  // Search upward from the port after the last winner, wrapping explicitly at NUM_S-1.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    cand        = 0;
    for (int i = 0; i < NUM_S; i++) begin
      cand = int'(last_ptr) + 1 + i;
      if (cand >= NUM_S) cand = cand - NUM_S;
      if (pick_onehot == '0 && i_s_tvalid[cand]) begin
        pick_onehot[cand] = 1'b1;
        pick_idx          = PTR_W'(cand);
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_switch_clk or posedge i_switch_rst) begin
    if (i_switch_rst) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_busy     <= 1'b0;
      o_m_tvalid <= 1'b0;
      o_m_tlast  <= 1'b0;
      o_m_tdest  <= '0;
      o_m_tdata  <= '0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
      last_ptr   <= PTR_W'(NUM_S - 1);
      grant_idx  <= '0;
`endif
    end else begin
      if (accept) begin
        o_m_tvalid <= 1'b1;
        o_m_tlast  <= sel_last;
        o_m_tdest  <= sel_dest;
        o_m_tdata  <= sel_data;
      end else if (i_m_tready) begin
        o_m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|i_s_tvalid) begin
            state   <= XFER;
            o_grant <= pick_onehot;
            o_busy  <= 1'b1;
`ifndef AXIS_ARB_FIXED_PRIO_EN
            grant_idx <= pick_idx;
`endif
          end
        end
        XFER: begin
          // Grant is released only once the packet's final beat is taken.
          if (accept && sel_last) begin
            state   <= IDLE;
            o_grant <= '0;
            o_busy  <= 1'b0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
            last_ptr <= grant_idx;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Cycle-accurate directed bench for axis_rr_arbiter (NUM_S=2): table-driven vectors plus async-reset sequence.
module tb_axis_rr_arbiter;

  localparam int NUM_S  = 2;
  localparam int DATA_W = 8;
  localparam int DEST_W = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_S-1:0]        s_tvalid;
  logic [NUM_S-1:0]        s_tlast;
  logic [NUM_S*DEST_W-1:0] s_tdest;
  logic [NUM_S*DATA_W-1:0] s_tdata;
  logic [NUM_S-1:0]        s_tready;
  logic                    m_tready;
  logic                    m_tvalid;
  logic                    m_tlast;
  logic [DEST_W-1:0]       m_tdest;
  logic [DATA_W-1:0]       m_tdata;
  logic [NUM_S-1:0]        grant;
  logic                    busy;

  axis_rr_arbiter #(
    .NUM_S (NUM_S),
    .DATA_W(DATA_W),
    .DEST_W(DEST_W)
  ) dut (
    .i_switch_clk(clk),
    .i_switch_rst(rst),
    .i_s_tvalid  (s_tvalid),
    .i_s_tlast   (s_tlast),
    .i_s_tdest   (s_tdest),
    .i_s_tdata   (s_tdata),
    .o_s_tready  (s_tready),
    .i_m_tready  (m_tready),
    .o_m_tvalid  (m_tvalid),
    .o_m_tlast   (m_tlast),
    .o_m_tdest   (m_tdest),
    .o_m_tdata   (m_tdata),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // One row = inputs held for one cycle, ready expected before the edge, registers expected after it.
  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       mrdy;
    logic [1:0] exp_rdy;
    logic [1:0] exp_grant;
    logic       exp_busy;
    logic       exp_mv;
    logic       exp_ml;
    logic [7:0] exp_md;
    logic [4:0] exp_mdest;
  } vec_t;

  vec_t vecs[64];
  int   n_vecs = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] vld, input logic [1:0] last,
                     input logic [7:0] d0, input logic [7:0] d1, input logic mrdy,
                     input logic [1:0] rdy, input logic [1:0] g, input logic b,
                     input logic mv, input logic ml, input logic [7:0] md, input logic [4:0] mdest);
    vecs[n_vecs].rst       = r;
    vecs[n_vecs].vld       = vld;
    vecs[n_vecs].last      = last;
    vecs[n_vecs].d0        = d0;
    vecs[n_vecs].d1        = d1;
    vecs[n_vecs].mrdy      = mrdy;
    vecs[n_vecs].exp_rdy   = rdy;
    vecs[n_vecs].exp_grant = g;
    vecs[n_vecs].exp_busy  = b;
    vecs[n_vecs].exp_mv    = mv;
    vecs[n_vecs].exp_ml    = ml;
    vecs[n_vecs].exp_md    = md;
    vecs[n_vecs].exp_mdest = mdest;
    n_vecs++;
  endtask

  initial begin
    // Single port: 3-beat packet A1..A3 from port0, first beat out two edges after tvalid.
    add(0, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b01, 2'b01, 1, 1, 0, 8'hA1, 5'h01);
    add(0, 2'b01, 2'b00, 8'hA2, 8'h00, 1, 2'b01, 2'b01, 1, 1, 0, 8'hA2, 5'h01);
    add(0, 2'b01, 2'b01, 8'hA3, 8'h00, 1, 2'b01, 2'b00, 0, 1, 1, 8'hA3, 5'h01);
    add(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 0, 0, 0, 8'h00, 5'h00);
    // Synchronous-looking reset row so contention starts from port0 again.
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 0, 0, 0, 8'h00, 5'h00);
`ifdef AXIS_ARB_FIXED_PRIO_EN
    // Both ports request continuously: only port0 packets ever come out.
    add(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b01, 2'b01, 1, 1, 0, 8'h10, 5'h01);
    add(0, 2'b11, 2'b01, 8'h11, 8'h20, 1, 2'b01, 2'b00, 0, 1, 1, 8'h11, 5'h01);
    add(0, 2'b11, 2'b00, 8'h30, 8'h20, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b11, 2'b01, 8'h30, 8'h20, 1, 2'b01, 2'b00, 0, 1, 1, 8'h30, 5'h01);
    add(0, 2'b11, 2'b00, 8'h31, 8'h20, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b11, 2'b01, 8'h31, 8'h20, 1, 2'b01, 2'b00, 0, 1, 1, 8'h31, 5'h01);
    add(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 0, 0, 0, 8'h00, 5'h00);
`else
    // Contention: 10,11 then 20,21 (port1 wins although port0 requests again), then port0 first again.
    add(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b11, 2'b00, 8'h10, 8'h20, 1, 2'b01, 2'b01, 1, 1, 0, 8'h10, 5'h01);
    add(0, 2'b11, 2'b01, 8'h11, 8'h20, 1, 2'b01, 2'b00, 0, 1, 1, 8'h11, 5'h01);
    add(0, 2'b11, 2'b00, 8'h30, 8'h20, 1, 2'b00, 2'b10, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b11, 2'b00, 8'h30, 8'h20, 1, 2'b10, 2'b10, 1, 1, 0, 8'h20, 5'h02);
    add(0, 2'b11, 2'b10, 8'h30, 8'h21, 1, 2'b10, 2'b00, 0, 1, 1, 8'h21, 5'h02);
    add(0, 2'b11, 2'b00, 8'h30, 8'h40, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b11, 2'b01, 8'h30, 8'h40, 1, 2'b01, 2'b00, 0, 1, 1, 8'h30, 5'h01);
    add(0, 2'b10, 2'b10, 8'h00, 8'h40, 1, 2'b00, 2'b10, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b10, 2'b10, 8'h00, 8'h40, 1, 2'b10, 2'b00, 0, 1, 1, 8'h40, 5'h02);
    add(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 0, 0, 0, 8'h00, 5'h00);
`endif
    // Backpressure for 3 cycles mid-packet while port1 waits; grant must stay on port0.
    add(0, 2'b01, 2'b00, 8'h50, 8'h00, 1, 2'b00, 2'b01, 1, 0, 0, 8'h00, 5'h00);
    add(0, 2'b01, 2'b00, 8'h50, 8'h00, 1, 2'b01, 2'b01, 1, 1, 0, 8'h50, 5'h01);
    add(0, 2'b11, 2'b00, 8'h51, 8'h60, 0, 2'b00, 2'b01, 1, 1, 0, 8'h50, 5'h01);
    add(0, 2'b11, 2'b00, 8'h51, 8'h60, 0, 2'b00, 2'b01, 1, 1, 0, 8'h50, 5'h01);
    add(0, 2'b11, 2'b00, 8'h51, 8'h60, 0, 2'b00, 2'b01, 1, 1, 0, 8'h50, 5'h01);
    add(0, 2'b11, 2'b00, 8'h51, 8'h60, 1, 2'b01, 2'b01, 1, 1, 0, 8'h51, 5'h01);
    add(0, 2'b11, 2'b01, 8'h52, 8'h60, 1, 2'b01, 2'b00, 0, 1, 1, 8'h52, 5'h01);
    add(0, 2'b10, 2'b00, 8'h00, 8'h60, 0, 2'b00, 2'b10, 1, 1, 1, 8'h52, 5'h01);
    add(0, 2'b10, 2'b00, 8'h00, 8'h60, 1, 2'b10, 2'b10, 1, 1, 0, 8'h60, 5'h02);

    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tdest  = {5'h02, 5'h01};
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset m_tvalid", 32'(m_tvalid), 32'd0);
    check("reset m_tdata",  32'(m_tdata),  32'd0);
    check("reset grant",    32'(grant),    32'd0);
    check("reset busy",     32'(busy),     32'd0);
    check("reset s_tready", 32'(s_tready), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < n_vecs; i++) begin
      rst      = vecs[i].rst;
      s_tvalid = vecs[i].vld;
      s_tlast  = vecs[i].last;
      s_tdata  = {vecs[i].d1, vecs[i].d0};
      m_tready = vecs[i].mrdy;
      @(negedge clk);
      check($sformatf("v%0d s_tready", i), 32'(s_tready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d grant", i),    32'(grant),    32'(vecs[i].exp_grant));
      check($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].exp_busy));
      check($sformatf("v%0d m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_mv));
      if (vecs[i].exp_mv) begin
        check($sformatf("v%0d m_tdata", i), 32'(m_tdata), 32'(vecs[i].exp_md));
        check($sformatf("v%0d m_tlast", i), 32'(m_tlast), 32'(vecs[i].exp_ml));
        check($sformatf("v%0d m_tdest", i), 32'(m_tdest), 32'(vecs[i].exp_mdest));
      end
    end

    // Reset mid-packet (port1 in XFER with a beat held): outputs clear without waiting for an edge.
    rst      = 1'b1;
    s_tvalid = 2'b11;
    s_tlast  = 2'b11;
    s_tdata  = {8'h80, 8'h70};
    m_tready = 1'b1;
    #1;
    check("async_rst m_tvalid", 32'(m_tvalid), 32'd0);
    check("async_rst m_tdata",  32'(m_tdata),  32'd0);
    check("async_rst grant",    32'(grant),    32'd0);
    check("async_rst busy",     32'(busy),     32'd0);
    check("async_rst s_tready", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst grant", 32'(grant), 32'b01);
    check("post_rst busy",  32'(busy),  32'd1);
    @(negedge clk);
    check("post_rst s_tready", 32'(s_tready), 32'b01);
    @(posedge clk);
    #1;
    check("post_rst m_tvalid", 32'(m_tvalid), 32'd1);
    check("post_rst m_tdata",  32'(m_tdata),  32'h70);
    check("post_rst m_tlast",  32'(m_tlast),  32'd1);
    check("post_rst m_tdest",  32'(m_tdest),  32'h01);
    check("post_rst grant_rel", 32'(grant),   32'd0);
    s_tvalid = '0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
